// File: rtl/wbs_pwm_ctrl.sv
// Wishbone B4 pipelined PWM slave: one shared counter with prescaler, edge or centre alignment,
// per-channel polarity, and shadow duty registers committed together at each period boundary.
module wbs_pwm_ctrl #(
  parameter int          RES_BITS     = 8,
  parameter int          CHANNEL_NUM  = 4,
  parameter int          ADDR_W       = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [ADDR_W-1:0]      wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_stall_o,
  output logic                   wb_ack_o,
  output logic [CHANNEL_NUM-1:0] pwm_channel,
  output logic                   period_o
);
  localparam logic [RES_BITS-1:0] CNT_TOP = {{(RES_BITS-1){1'b1}}, 1'b0};

  // Handshake: a request is cyc&stb on any clock (stall never rises); every request is acked
  // exactly one clock later, and read data is presented in wb_dat_o on that same ack clock.
  logic        req, wr, wr_pre;
  logic [31:0] adr;
  assign req    = wb_cyc_i & wb_stb_i;
  assign wr     = req & wb_we_i;
  assign adr    = 32'(wb_adr_i);
  assign wr_pre = wr && (adr == 32'd1);

  logic                   en_q, en_d, center_q, center_d, center_act_q, center_act_d;
  logic                   dir_q, dir_d, sync_clr, run, tick, en_rise, at_wrap, commit;
  logic [15:0]            prescale_q, prescale_d, pre_cnt_q, pre_cnt_d, status_q, status_d;
  logic [CHANNEL_NUM-1:0] invert_q, invert_d, pwm_q, pwm_d;
  logic [RES_BITS-1:0]    cnt_q, cnt_d;
  logic [RES_BITS-1:0]    shadow_q [CHANNEL_NUM];
  logic [RES_BITS-1:0]    shadow_d [CHANNEL_NUM];
  logic [RES_BITS-1:0]    active_q [CHANNEL_NUM];
  logic [RES_BITS-1:0]    active_d [CHANNEL_NUM];
  logic                   ack_q, ack_d, period_q, period_d;
  logic [31:0]            dat_q, dat_d, rd_data;
  logic                   unused_bits;

  assign unused_bits = &{1'b0, wb_dat_i[31:16]};

  always_comb begin
    en_d       = en_q;
    center_d   = center_q;
    sync_clr   = 1'b0;
    prescale_d = prescale_q;
    invert_d   = invert_q;
    shadow_d   = shadow_q;
    if (wr && adr == 32'd0) begin
      en_d     = wb_dat_i[0];
      center_d = wb_dat_i[1];
      sync_clr = wb_dat_i[2];
    end
    if (wr_pre) prescale_d = wb_dat_i[15:0];
    if (wr && adr == 32'd2) invert_d = wb_dat_i[CHANNEL_NUM-1:0];
    for (int n = 0; n < CHANNEL_NUM; n++) begin
      if (wr && adr == 32'(4 + n)) shadow_d[n] = wb_dat_i[RES_BITS-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    if (adr == 32'd0)      rd_data = {30'd0, center_q, en_q};
    else if (adr == 32'd1) rd_data = {16'd0, prescale_q};
    else if (adr == 32'd2) rd_data = 32'(invert_q);
    else if (adr == 32'd3) rd_data = {16'd0, status_q};
    for (int n = 0; n < CHANNEL_NUM; n++) begin
      if (adr == 32'(4 + n)) rd_data = 32'(shadow_q[n]);
    end
  end

  // Centre mode commits on the bottom hold tick, so the new period's first sample (cnt=0, rising)
  // already uses the new duties, exactly as in edge mode.
  always_comb begin
    run     = en_q & en_d;
    tick    = run && (pre_cnt_q == prescale_q);
    at_wrap = center_act_q ? (cnt_q == '0 && dir_q) : (cnt_q == CNT_TOP);
    en_rise = en_d & ~en_q;
    commit  = (tick & at_wrap) | en_rise | sync_clr;

    cnt_d        = cnt_q;
    dir_d        = dir_q;
    pre_cnt_d    = pre_cnt_q;
    center_act_d = center_act_q;
    if (!run || sync_clr) begin
      cnt_d     = '0;
      dir_d     = 1'b0;
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = (tick || wr_pre) ? 16'd0 : pre_cnt_q + 16'd1;
      if (tick) begin
        if (!center_act_q) begin
          cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
        end else if (!dir_q) begin
          if (cnt_q == CNT_TOP) dir_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end else begin
          if (cnt_q == '0) dir_d = 1'b0;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
    end
    if (commit) center_act_d = center_d;

    active_d = active_q;
    if (commit) active_d = shadow_d;
    status_d = status_q + {15'd0, commit};
    period_d = commit;

    for (int n = 0; n < CHANNEL_NUM; n++) begin
      pwm_d[n] = en_q ? ((cnt_q < active_q[n]) ^ invert_q[n]) : invert_q[n];
    end

    ack_d = req;
    dat_d = (req && !wb_we_i) ? rd_data : 32'd0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en_q         <= 1'b0;
      center_q     <= 1'b0;
      center_act_q <= 1'b0;
      dir_q        <= 1'b0;
      prescale_q   <= PRESCALE_RST;
      pre_cnt_q    <= '0;
      status_q     <= '0;
      invert_q     <= '0;
      pwm_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      ack_q        <= 1'b0;
      period_q     <= 1'b0;
      dat_q        <= '0;
    end else begin
      en_q         <= en_d;
      center_q     <= center_d;
      center_act_q <= center_act_d;
      dir_q        <= dir_d;
      prescale_q   <= prescale_d;
      pre_cnt_q    <= pre_cnt_d;
      status_q     <= status_d;
      invert_q     <= invert_d;
      pwm_q        <= pwm_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      ack_q        <= ack_d;
      period_q     <= period_d;
      dat_q        <= dat_d;
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_stall_o  = 1'b0;
  assign pwm_channel = pwm_q;
  assign period_o    = period_q;
endmodule

// File: tb/tb_wbs_pwm_ctrl.sv
// Bench for wbs_pwm_ctrl: randomized register setups checked cycle by cycle against a
// period/tick arithmetic model of the PWM waveform, plus bus map and reset scenarios.
module tb_wbs_pwm_ctrl;
  localparam int RES_BITS = 8;
  localparam int CH       = 4;
  localparam int MAX      = (1 << RES_BITS) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        stall, ack, period;
  logic [3:0]  pwm;

  int checks = 0;
  int failures = 0;

  // model state
  int         m_pre;
  bit         m_center;
  logic [3:0] m_inv;
  int         m_shadow [CH];
  int         m_active [CH];
  int         m_status = 0;

  wbs_pwm_ctrl #(.RES_BITS(RES_BITS), .CHANNEL_NUM(CH), .ADDR_W(4), .PRESCALE_RST(16'd0)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_stall_o(stall), .wb_ack_o(ack),
    .pwm_channel(pwm), .period_o(period)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk); cyc = 1; stb = 1; we = 1; adr = 4'(a); dat_i = d;
    @(negedge clk); cyc = 0; stb = 0; we = 0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d, output logic k);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 4'(a);
    @(negedge clk); d = dat_o; k = ack; cyc = 0; stb = 0;
  endtask

  task automatic setup(input int pre, input bit center, input logic [3:0] inv,
                       input int d0, input int d1, input int d2, input int d3);
    int d [CH];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bus_write(0, 32'd0);
    bus_write(1, (32'($urandom) << 16) | 32'(pre));
    bus_write(2, (32'($urandom) << 4) | 32'(inv));
    for (int n = 0; n < CH; n++) begin
      bus_write(4 + n, (32'($urandom) << RES_BITS) | 32'(d[n]));
      m_shadow[n] = d[n];
    end
    m_pre = pre; m_center = center; m_inv = inv;
  endtask

  task automatic drive_ctrl(input logic [31:0] v);
    cyc = 1; stb = 1; we = 1; adr = 4'd0; dat_i = v;
  endtask

  // ---------------- reference model ----------------
  function automatic int period_len();
    return m_center ? 2 * MAX : MAX;
  endfunction

  // counter value after t ticks of the current period pattern
  function automatic int cnt_of(input int t);
    int pos;
    pos = t % period_len();
    if (m_center && pos >= MAX) return 2 * MAX - 1 - pos;
    return pos;
  endfunction

  // expected outputs just after the i-th clock edge counted from the enabling edge (i=0)
  task automatic model_step(input int i, output logic [3:0] ep, output logic eper);
    int tp, tn;
    if (i == 0) begin
      ep = m_inv; eper = 1'b1;
    end else begin
      tp = (i - 1) / (m_pre + 1);
      tn = i / (m_pre + 1);
      for (int n = 0; n < CH; n++) ep[n] = (cnt_of(tp) < m_active[n]) ^ m_inv[n];
      eper = (tn != tp) && (tn % period_len() == 0);
    end
    if (eper) begin
      m_active = m_shadow;
      m_status = (m_status + 1) & 32'hFFFF;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic k;
    #3;
    checks++; if (pwm !== 4'h0) begin failures++; $display("FAIL reset_pwm got=%h exp=0", pwm); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (period !== 1'b0) begin failures++; $display("FAIL reset_period got=%b exp=0", period); end
    checks++; if (dat_o !== 32'd0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(0, d, k);
    checks++; if (k !== 1'b1) begin failures++; $display("FAIL reset_read_ack got=%b exp=1", k); end
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    bus_read(1, d, k);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_prescale got=%h exp=0", d); end
    bus_read(3, d, k);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
  endtask

  task automatic test_edge();
    logic [3:0] ep; logic eper; logic [31:0] d; logic k;
    int n = 600;
    setup(0, 0, 4'h8, 64, 0, MAX, 0);
    @(negedge clk); drive_ctrl(32'h1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cyc = 0; stb = 0; we = 0;
      model_step(i, ep, eper);
      checks++; if (pwm !== ep) begin failures++; $display("FAIL edge_pwm i=%0d got=%b exp=%b", i, pwm, ep); end
      checks++; if (period !== eper) begin failures++; $display("FAIL edge_period i=%0d got=%b exp=%b", i, period, eper); end
      if (i == n - 1) drive_ctrl(32'h0);
    end
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    checks++; if (pwm !== m_inv) begin failures++; $display("FAIL edge_en_off got=%b exp=%b", pwm, m_inv); end
    bus_read(3, d, k);
    checks++; if (d !== 32'(m_status)) begin failures++; $display("FAIL edge_status got=%0d exp=%0d", d, m_status); end
  endtask

  task automatic test_duty_update();
    logic [3:0] ep; logic eper;
    int n = 800, wr_at = 265;
    setup(0, 0, 4'h0, 64, $urandom_range(0, MAX), $urandom_range(0, MAX), $urandom_range(0, MAX));
    @(negedge clk); drive_ctrl(32'h1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cyc = 0; stb = 0; we = 0;
      if (i == wr_at + 1) m_shadow[0] = 200;
      model_step(i, ep, eper);
      checks++; if (pwm !== ep) begin failures++; $display("FAIL duty_pwm i=%0d got=%b exp=%b", i, pwm, ep); end
      checks++; if (period !== eper) begin failures++; $display("FAIL duty_period i=%0d got=%b exp=%b", i, period, eper); end
      if (i == wr_at) begin cyc = 1; stb = 1; we = 1; adr = 4'd4; dat_i = (32'($urandom) << 8) | 32'd200; end
      if (i == n - 1) drive_ctrl(32'h0);
    end
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    checks++; if (pwm !== m_inv) begin failures++; $display("FAIL duty_en_off got=%b exp=%b", pwm, m_inv); end
  endtask

  task automatic test_center();
    logic [3:0] ep; logic eper; logic [31:0] d; logic k;
    int n = 2100;
    setup(1, 1, 4'h0, 64, $urandom_range(0, MAX), 0, MAX);
    @(negedge clk); drive_ctrl(32'h3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cyc = 0; stb = 0; we = 0;
      model_step(i, ep, eper);
      checks++; if (pwm !== ep) begin failures++; $display("FAIL center_pwm i=%0d got=%b exp=%b", i, pwm, ep); end
      checks++; if (period !== eper) begin failures++; $display("FAIL center_period i=%0d got=%b exp=%b", i, period, eper); end
      if (i == n - 1) drive_ctrl(32'h0);
    end
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    bus_read(3, d, k);
    checks++; if (d !== 32'(m_status)) begin failures++; $display("FAIL center_status got=%0d exp=%0d", d, m_status); end
  endtask

  task automatic test_random();
    logic [3:0] ep; logic eper;
    int n, wr_at, wr_ch, wr_val;
    for (int r = 0; r < 3; r++) begin
      setup($urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'($urandom),
            $urandom_range(0, MAX), $urandom_range(0, MAX), $urandom_range(0, MAX), $urandom_range(0, MAX));
      n = 2 * period_len() * (m_pre + 1) + 50;
      wr_at = $urandom_range(5, n - 20);
      wr_ch = $urandom_range(0, CH - 1);
      wr_val = $urandom_range(0, MAX);
      @(negedge clk); drive_ctrl({30'd0, m_center, 1'b1});
      for (int i = 0; i < n; i++) begin
        @(negedge clk); cyc = 0; stb = 0; we = 0;
        if (i == wr_at + 1) m_shadow[wr_ch] = wr_val;
        model_step(i, ep, eper);
        checks++; if (pwm !== ep) begin failures++; $display("FAIL rand_pwm r=%0d i=%0d got=%b exp=%b", r, i, pwm, ep); end
        checks++; if (period !== eper) begin failures++; $display("FAIL rand_period r=%0d i=%0d got=%b exp=%b", r, i, period, eper); end
        if (i == wr_at) begin cyc = 1; stb = 1; we = 1; adr = 4'(4 + wr_ch); dat_i = (32'($urandom) << 8) | 32'(wr_val); end
        if (i == n - 1) drive_ctrl(32'h0);
      end
      @(negedge clk); cyc = 0; stb = 0; we = 0;
      @(negedge clk);
      checks++; if (pwm !== m_inv) begin failures++; $display("FAIL rand_en_off r=%0d got=%b exp=%b", r, pwm, m_inv); end
    end
  endtask

  task automatic test_sync_clr();
    logic [31:0] d; logic k;
    setup(1000, 0, 4'h0, 10, 20, 30, 40);
    bus_write(0, 32'h1);
    m_status = (m_status + 1) & 32'hFFFF;
    bus_read(3, d, k);
    checks++; if (d !== 32'(m_status)) begin failures++; $display("FAIL sync_en_commit got=%0d exp=%0d", d, m_status); end
    bus_write(0, 32'h5);
    m_status = (m_status + 1) & 32'hFFFF;
    bus_read(3, d, k);
    checks++; if (d !== 32'(m_status)) begin failures++; $display("FAIL sync_commit got=%0d exp=%0d", d, m_status); end
    bus_read(0, d, k);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL sync_ctrl_read got=%h exp=1", d); end
    bus_write(0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int adrs [10];
    int pre; logic [3:0] inv; int dv [CH];
    pre = $urandom_range(0, 16'hFFFF);
    inv = 4'($urandom);
    bus_write(0, 32'h2);
    bus_write(1, 32'(pre));
    bus_write(2, 32'(inv));
    bus_write(3, 32'h1234);
    bus_write(9, 32'hFFFF_FFFF);
    for (int n = 0; n < CH; n++) begin
      dv[n] = $urandom_range(0, MAX);
      bus_write(4 + n, (32'($urandom) << 8) | 32'(dv[n]));
    end
    for (int a = 0; a < 9; a++) adrs[a] = a;
    adrs[9] = 15;
    exp_q = '{32'h2, 32'(pre), 32'(inv), 32'(m_status), 32'(dv[0]), 32'(dv[1]), 32'(dv[2]), 32'(dv[3]), 32'h0, 32'h0};
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall k=%0d got=%b exp=0", k, stall); end
      if (k > 0) begin
        e = exp_q.pop_front();
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL b2b_ack k=%0d got=%b exp=1", k, ack); end
        checks++; if (dat_o !== e) begin failures++; $display("FAIL b2b_data adr=%0d got=%h exp=%h", adrs[k-1], dat_o, e); end
      end
      if (k < 10) begin cyc = 1; stb = 1; we = 0; adr = 4'(adrs[k]); end
      else begin cyc = 0; stb = 0; end
    end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_end got=%b exp=0", ack); end
    bus_write(0, 32'h0);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d; logic k;
    setup(5, 0, 4'h0, MAX, MAX, MAX, MAX);
    bus_write(0, 32'h1);
    repeat (20) @(negedge clk);
    checks++; if (pwm !== 4'hF) begin failures++; $display("FAIL midrun_full got=%b exp=1111", pwm); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm !== 4'h0) begin failures++; $display("FAIL midrun_async got=%b exp=0000", pwm); end
    @(negedge clk); rst_n = 1'b1;
    m_status = 0;
    bus_read(0, d, k);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL midrun_ctrl got=%h exp=0", d); end
    bus_read(1, d, k);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL midrun_prescale got=%h exp=0", d); end
    bus_read(4, d, k);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL midrun_duty0 got=%h exp=0", d); end
    checks++; if (pwm !== 4'h0) begin failures++; $display("FAIL midrun_pwm_after got=%b exp=0000", pwm); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_duty_update();
    test_center();
    test_random();
    test_sync_clr();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
